// File: rtl/ahb_rand_pkg.sv
// Shared types and helpers for the random AHB-Lite traffic master.
// Holds the bus encodings, the FSM state type and the command decoder.
package ahb_rand_pkg;

    typedef enum logic [1:0] {
        TransIdle   = 2'b00,
        TransBusy   = 2'b01,
        TransNonseq = 2'b10,
        TransSeq    = 2'b11
    } htrans_t;

    localparam logic [2:0] HburstSingle = 3'b000;
    localparam logic [2:0] HburstIncr4  = 3'b011;
    localparam logic [2:0] HsizeWord    = 3'b010;
    localparam logic [3:0] HprotDefault = 4'b0011;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StSeq,
        StGap
    } state_t;

    typedef struct packed {
        logic        write;
        logic        incr4;
        logic [1:0]  gap;
        logic [31:0] addr;
    } cmd_t;

    // Start address is forced 16-byte aligned so an INCR4 never leaves its block.
    function automatic cmd_t decode_cmd(input logic [31:0] word, input logic [31:0] base,
                                        input logic [31:0] win_mask);
        cmd_t c;
        c.write = word[0];
        c.incr4 = word[1];
        c.gap   = word[3:2];
        c.addr  = base | (word & win_mask & 32'hFFFF_FFF0);
        return c;
    endfunction

endpackage

// File: rtl/ahb_rand_master.sv
// Turns a free-running random word into legal AHB-Lite SINGLE/INCR4 word transfers
// inside an address window, with random idle gaps and completion/error/read-data status.
module ahb_rand_master
    import ahb_rand_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int unsigned WIN_LOG2  = 12,
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enable,
    input  logic [31:0]          rand_val,
    input  logic                 HREADY,
    input  logic                 HRESP,
    input  logic [31:0]          HRDATA,
    output logic [31:0]          HADDR,
    output logic [1:0]           HTRANS,
    output logic                 HWRITE,
    output logic [2:0]           HSIZE,
    output logic [2:0]           HBURST,
    output logic [31:0]          HWDATA,
    output logic [3:0]           HPROT,
    output logic                 HMASTLOCK,
    output logic                 busy,
    output logic                 txn_done,
    output logic [31:0]          txn_count,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [31:0]          rd_xor
);

    localparam logic [31:0] WinMask = 32'((64'd1 << WIN_LOG2) - 64'd1);

    state_t                state_q, state_d;
    cmd_t                  cmd_q;
    logic [1:0]            beat_q;
    logic [1:0]            gap_q;
    logic                  dp_valid_q, dp_write_q, dp_last_q;
    logic [31:0]           hwdata_q;
    logic [31:0]           txn_count_q;
    logic [ERR_CNT_W-1:0]  err_count_q;
    logic [31:0]           rd_xor_q;

    logic load_cmd;
    logic accept;
    logic addr_last;
    logic err_first;
    logic beat_done;

    assign accept    = HREADY && (state_q == StAddr || state_q == StSeq);
    assign addr_last = !cmd_q.incr4 || beat_q == 2'd3;
    assign err_first = dp_valid_q && HRESP && !HREADY;
    assign beat_done = dp_valid_q && HREADY;

    always_ff @(posedge clk) begin
        if (!rstn) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        load_cmd = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d  = StAddr;
                    load_cmd = 1'b1;
                end
            end
            StAddr, StSeq: begin
                // An error response abandons whatever is on the address bus.
                if (err_first) begin
                    state_d = StGap;
                end else if (accept) begin
                    if (!addr_last) begin
                        state_d = StSeq;
                    end else if (cmd_q.gap != 2'd0) begin
                        state_d = StGap;
                    end else if (enable) begin
                        state_d  = StAddr;
                        load_cmd = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StGap: begin
                if (gap_q == 2'd0) begin
                    if (enable) begin
                        state_d  = StAddr;
                        load_cmd = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        HTRANS = TransIdle;
        unique case (state_q)
            StAddr:  HTRANS = TransNonseq;
            StSeq:   HTRANS = TransSeq;
            default: HTRANS = TransIdle;
        endcase
        busy = (state_q == StAddr || state_q == StSeq) || dp_valid_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cmd_q       <= '0;
            beat_q      <= 2'd0;
            gap_q       <= 2'd0;
            dp_valid_q  <= 1'b0;
            dp_write_q  <= 1'b0;
            dp_last_q   <= 1'b0;
            hwdata_q    <= 32'd0;
            txn_count_q <= 32'd0;
            err_count_q <= '0;
            rd_xor_q    <= 32'd0;
        end else begin
            if (load_cmd) begin
                cmd_q  <= decode_cmd(rand_val, ADDR_BASE, WinMask);
                beat_q <= 2'd0;
            end else if (accept && !addr_last) begin
                cmd_q.addr <= cmd_q.addr + 32'd4;
                beat_q     <= beat_q + 2'd1;
            end

            // Gap counter holds (cycles - 1); an error gap is a single idle cycle.
            if (state_q != StGap && state_d == StGap) begin
                gap_q <= err_first ? 2'd0 : cmd_q.gap - 2'd1;
            end else if (state_q == StGap && gap_q != 2'd0) begin
                gap_q <= gap_q - 2'd1;
            end

            if (HREADY) begin
                dp_valid_q <= accept;
                if (accept) begin
                    dp_write_q <= cmd_q.write;
                    dp_last_q  <= addr_last;
                    hwdata_q   <= rand_val;
                end
            end

            if (txn_done) txn_count_q <= txn_count_q + 32'd1;
            if (err_first && err_count_q != '1) err_count_q <= err_count_q + 1'b1;
            if (beat_done && !HRESP && !dp_write_q) rd_xor_q <= rd_xor_q ^ HRDATA;
        end
    end

    assign txn_done  = beat_done && (dp_last_q || HRESP);
    assign HADDR     = cmd_q.addr;
    assign HWRITE    = cmd_q.write;
    assign HBURST    = cmd_q.incr4 ? HburstIncr4 : HburstSingle;
    assign HSIZE     = HsizeWord;
    assign HWDATA    = hwdata_q;
    assign HPROT     = HprotDefault;
    assign HMASTLOCK = 1'b0;
    assign txn_count = txn_count_q;
    assign err_count = err_count_q;
    assign rd_xor    = rd_xor_q;

endmodule

// File: tb/tb_ahb_rand_master.sv
// Bench for ahb_rand_master: directed scenarios plus random traffic against a
// transaction-level model that tracks beats remaining, gap cycles and the data phase.
module tb_ahb_rand_master;

    localparam int unsigned ErrW = 4;
    localparam int          ErrMax = (1 << ErrW) - 1;
    localparam logic [31:0] OffMask = 32'h0000_0FF0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstn, enable, HREADY, HRESP;
    logic [31:0]     rand_val, HRDATA;
    logic [31:0]     HADDR, HWDATA, txn_count, rd_xor;
    logic [1:0]      HTRANS;
    logic            HWRITE, HMASTLOCK, busy, txn_done;
    logic [2:0]      HSIZE, HBURST;
    logic [3:0]      HPROT;
    logic [ErrW-1:0] err_count;

    ahb_rand_master #(
        .ADDR_BASE(32'h0000_0000),
        .WIN_LOG2 (12),
        .ERR_CNT_W(ErrW)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .enable   (enable),
        .rand_val (rand_val),
        .HREADY   (HREADY),
        .HRESP    (HRESP),
        .HRDATA   (HRDATA),
        .HADDR    (HADDR),
        .HTRANS   (HTRANS),
        .HWRITE   (HWRITE),
        .HSIZE    (HSIZE),
        .HBURST   (HBURST),
        .HWDATA   (HWDATA),
        .HPROT    (HPROT),
        .HMASTLOCK(HMASTLOCK),
        .busy     (busy),
        .txn_done (txn_done),
        .txn_count(txn_count),
        .err_count(err_count),
        .rd_xor   (rd_xor)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0] m_start, m_wd, m_cnt, m_xor;
    logic        m_wr, m_inc, m_dv, m_dw, m_dl;
    int          m_left, m_idx, m_idle, m_gap, m_errs;

    // Measurements taken from the bus
    int idle_run, last_gap, acc_beats, done_pulses;
    logic err_stage;

    task automatic model_reset();
        m_start = 32'd0; m_wd = 32'd0; m_cnt = 32'd0; m_xor = 32'd0;
        m_wr = 1'b0; m_inc = 1'b0; m_dv = 1'b0; m_dw = 1'b0; m_dl = 1'b0;
        m_left = 0; m_idx = 0; m_idle = 0; m_gap = 0; m_errs = 0;
    endtask

    task automatic start_cmd(input logic [31:0] rv);
        m_start = rv & OffMask;
        m_wr    = rv[0];
        m_inc   = rv[1];
        m_gap   = int'(rv[3:2]);
        m_left  = rv[1] ? 4 : 1;
        m_idx   = 0;
    endtask

    task automatic model_step(input logic en, input logic [31:0] rv, input logic rdy,
                              input logic rsp, input logic [31:0] rd);
        bit on, ef;
        on = (m_left > 0);
        ef = m_dv && rsp && !rdy;
        if (m_dv && rdy && (m_dl || rsp)) m_cnt = m_cnt + 32'd1;
        if (ef) m_errs++;
        if (m_dv && rdy && !rsp && !m_dw) m_xor = m_xor ^ rd;
        if (rdy) begin
            m_dv = on;
            if (on) begin
                m_dw = m_wr;
                m_dl = (m_left == 1);
                m_wd = rv;
            end
        end
        if (ef && on) begin
            m_left = 0;
            m_idle = 1;
        end else if (on) begin
            if (rdy) begin
                m_idx++;
                m_left--;
                if (m_left == 0) begin
                    if (m_gap > 0) m_idle = m_gap;
                    else if (en)   start_cmd(rv);
                end
            end
        end else if (m_idle > 0) begin
            m_idle--;
            if (m_idle == 0 && en) start_cmd(rv);
        end else if (en) begin
            start_cmd(rv);
        end
    endtask

    task automatic check_outputs(input logic rdy, input logic rsp);
        bit on;
        int exp_err;
        on = (m_left > 0);
        exp_err = (m_errs > ErrMax) ? ErrMax : m_errs;
        check_eq("htrans", 32'(HTRANS), on ? ((m_idx == 0) ? 32'd2 : 32'd3) : 32'd0);
        if (on) begin
            check_eq("haddr", HADDR, m_start + 32'(m_idx) * 32'd4);
            check_eq("hwrite", 32'(HWRITE), 32'(m_wr));
            check_eq("hburst", 32'(HBURST), m_inc ? 32'd3 : 32'd0);
        end
        if (m_dv && m_dw) check_eq("hwdata", HWDATA, m_wd);
        check_eq("busy", 32'(busy), 32'(on || m_dv));
        check_eq("txn_done", 32'(txn_done), 32'(m_dv && rdy && (m_dl || rsp)));
        check_eq("txn_count", txn_count, m_cnt);
        check_eq("err_count", 32'(err_count), 32'(exp_err));
        check_eq("rd_xor", rd_xor, m_xor);
    endtask

    task automatic run_cycle(input logic rst, input logic en, input logic [31:0] rv,
                             input logic rdy, input logic rsp, input logic [31:0] rd);
        rstn = !rst; enable = en; rand_val = rv; HREADY = rdy; HRESP = rsp; HRDATA = rd;
        @(negedge clk);
        check_outputs(rdy, rsp);
        if (HTRANS == 2'b00) begin
            idle_run++;
        end else if (HTRANS == 2'b10) begin
            last_gap = idle_run;
            idle_run = 0;
        end
        if (HTRANS[1] && rdy) acc_beats++;
        if (txn_done) done_pulses++;
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(en, rv, rdy, rsp, rd);
        #1;
    endtask

    task automatic clear_meas();
        idle_run = 0; last_gap = 0; acc_beats = 0; done_pulses = 0;
    endtask

    task automatic do_reset();
        run_cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        err_stage = 1'b0;
        clear_meas();
    endtask

    // Legal two-cycle ERROR responses, random wait states and read data.
    task automatic rand_cycle(input logic en, input int err_pct);
        logic rdy, rsp;
        if (err_stage) begin
            rdy = 1'b1; rsp = 1'b1; err_stage = 1'b0;
        end else if (m_dv && int'($urandom_range(99)) < err_pct) begin
            rdy = 1'b0; rsp = 1'b1; err_stage = 1'b1;
        end else begin
            rsp = 1'b0; rdy = ($urandom_range(3) != 0);
        end
        run_cycle(1'b0, en, $urandom, rdy, rsp, $urandom);
    endtask

    logic [31:0] rds [8];
    logic        rdy3 [12];
    logic        en_r;

    initial begin
        model_reset();
        err_stage = 1'b0;
        clear_meas();
        run_cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        do_reset();
        check_eq("rst_htrans", 32'(HTRANS), 32'd0);
        check_eq("rst_haddr", HADDR, 32'd0);
        check_eq("rst_hwrite", 32'(HWRITE), 32'd0);
        check_eq("rst_hburst", 32'(HBURST), 32'd0);
        check_eq("rst_hsize", 32'(HSIZE), 32'd2);
        check_eq("rst_hwdata", HWDATA, 32'd0);
        check_eq("rst_hprot", 32'(HPROT), 32'd3);
        check_eq("rst_hmastlock", 32'(HMASTLOCK), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_counts", txn_count | rd_xor | 32'(err_count), 32'd0);

        // Back-to-back write SINGLEs
        for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b1, 32'h1, 1'b1, 1'b0, 32'd0);
        check_eq("t1_beats", 32'(acc_beats), 32'd5);
        check_eq("t1_done", 32'(done_pulses), 32'd4);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, 32'h1, 1'b1, 1'b0, 32'd0);

        // Read INCR4 at 0x120, read data 1,2,4,8
        do_reset();
        rds = '{32'd0, 32'd0, 32'd1, 32'd2, 32'd4, 32'd8, 32'd0, 32'd0};
        for (int i = 0; i < 8; i++) run_cycle(1'b0, i == 0, 32'h122, 1'b1, 1'b0, rds[i]);
        check_eq("t2_rd_xor", rd_xor, 32'hF);
        check_eq("t2_txn_count", txn_count, 32'd1);
        check_eq("t2_beats", 32'(acc_beats), 32'd4);

        // Write INCR4 with three wait states on beat 2
        do_reset();
        rdy3 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 12; i++)
            run_cycle(1'b0, i == 0, (i == 0) ? 32'h123 : $urandom, rdy3[i], 1'b0, 32'd0);
        check_eq("t3_beats", 32'(acc_beats), 32'd4);
        check_eq("t3_done", 32'(done_pulses), 32'd1);

        // ERROR on the first beat of a read INCR4
        do_reset();
        run_cycle(1'b0, 1'b1, 32'h2, 1'b1, 1'b0, 32'd0);
        run_cycle(1'b0, 1'b0, 32'h2, 1'b1, 1'b0, 32'd0);
        run_cycle(1'b0, 1'b0, 32'h2, 1'b0, 1'b1, 32'h55);
        run_cycle(1'b0, 1'b0, 32'h2, 1'b1, 1'b1, 32'h55);
        for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b0, 32'h2, 1'b1, 1'b0, 32'd0);
        check_eq("t4_beats", 32'(acc_beats), 32'd1);
        check_eq("t4_done", 32'(done_pulses), 32'd1);
        check_eq("t4_err", 32'(err_count), 32'd1);
        check_eq("t4_rd_xor", rd_xor, 32'd0);

        // Gap of 3 idle cycles
        do_reset();
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 1'b1, 32'h0C, 1'b1, 1'b0, 32'd0);
        check_eq("t5_gap", 32'(last_gap), 32'd3);

        // Enable dropped during beat 2
        do_reset();
        for (int i = 0; i < 10; i++) run_cycle(1'b0, i < 3, 32'h122, 1'b1, 1'b0, 32'd0);
        check_eq("t5_beats", 32'(acc_beats), 32'd4);
        check_eq("t5_idle", 32'(HTRANS), 32'd0);
        check_eq("t5_busy", 32'(busy), 32'd0);

        // Random traffic, then an error storm to saturate err_count
        do_reset();
        en_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19) == 0) en_r = !en_r;
            rand_cycle(en_r, 5);
        end
        for (int i = 0; i < 300; i++) rand_cycle(1'b1, 90);
        for (int i = 0; i < 4; i++) rand_cycle(1'b1, 0);
        check_eq("t4_err_sat", 32'(err_count), 32'(ErrMax));

        // Reset in the middle of a write INCR4
        run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) rand_cycle(1'b0, 0);
        run_cycle(1'b0, 1'b1, 32'h123, 1'b1, 1'b0, 32'd0);
        run_cycle(1'b0, 1'b1, 32'h123, 1'b1, 1'b0, 32'd0);
        run_cycle(1'b0, 1'b1, 32'h123, 1'b1, 1'b0, 32'd0);
        run_cycle(1'b1, 1'b1, 32'h123, 1'b1, 1'b0, 32'd0);
        check_eq("t6_htrans", 32'(HTRANS), 32'd0);
        check_eq("t6_haddr", HADDR, 32'd0);
        check_eq("t6_hwdata", HWDATA, 32'd0);
        check_eq("t6_busy", 32'(busy), 32'd0);
        check_eq("t6_done", 32'(txn_done), 32'd0);
        check_eq("t6_txn_count", txn_count, 32'd0);
        check_eq("t6_err_count", 32'(err_count), 32'd0);
        check_eq("t6_rd_xor", rd_xor, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
